// File: rtl/param_mem_loader.sv
// param_mem_loader: framed byte-stream loader for the shared parameter RAM.
// Parses SYNC/address/length header, writes payload, checks range and checksum.
module param_mem_loader #(
    parameter int         ADDR_WIDTH = 14,
    parameter int         MEM_DEPTH  = 13514,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mem_lock,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [7:0]            mem_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            status
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN_HI,
        S_LEN_LO,
        S_CHECK,
        S_PAYLOAD,
        S_CHECKSUM,
        S_DISCARD,
        S_REPORT
    } state_t;

    state_t                state;
    logic [7:0]            hi_byte;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [15:0]           length;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [16:0]           remaining;
    logic [7:0]            sum;
    logic [16:0]           range_end;
    logic                  accept;

    // CHECK and REPORT are the two bubble states; the lock blocks every state.
    assign in_ready  = !rst && !mem_lock && (state != S_CHECK) && (state != S_REPORT);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != S_IDLE);
    assign range_end = 17'(start_addr) + 17'(length);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            hi_byte     <= '0;
            start_addr  <= '0;
            length      <= '0;
            wr_ptr      <= '0;
            remaining   <= '0;
            sum         <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            done        <= 1'b0;
            status      <= 2'd0;
        end else begin
            mem_wr_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        sum       <= '0;
                        remaining <= '0;
                        state     <= S_ADDR_HI;
                    end
                end
                S_ADDR_HI: begin
                    if (accept) begin
                        hi_byte <= in_data;
                        state   <= S_ADDR_LO;
                    end
                end
                S_ADDR_LO: begin
                    // Only the low ADDR_WIDTH bits of the 16-bit address are kept.
                    if (accept) begin
                        start_addr <= ADDR_WIDTH'({hi_byte, in_data});
                        state      <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        hi_byte <= in_data;
                        state   <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        length <= {hi_byte, in_data};
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    wr_ptr <= start_addr;
                    if (range_end > 17'(MEM_DEPTH)) begin
                        remaining <= 17'(length) + 17'd1;
                        state     <= S_DISCARD;
                    end else begin
                        remaining <= 17'(length);
                        state     <= (length != 16'd0) ? S_PAYLOAD : S_CHECKSUM;
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= wr_ptr;
                        mem_wr_data <= in_data;
                        wr_ptr      <= wr_ptr + 1'b1;
                        sum         <= sum + in_data;
                        remaining   <= remaining - 17'd1;
                        if (remaining == 17'd1) begin
                            state <= S_CHECKSUM;
                        end
                    end
                end
                S_CHECKSUM: begin
                    if (accept) begin
                        status <= (in_data == sum) ? 2'd0 : 2'd1;
                        done   <= 1'b1;
                        state  <= S_REPORT;
                    end
                end
                S_DISCARD: begin
                    // Swallows the rest of a rejected frame, checksum byte included.
                    if (accept) begin
                        remaining <= remaining - 17'd1;
                        if (remaining == 17'd1) begin
                            status <= 2'd2;
                            done   <= 1'b1;
                            state  <= S_REPORT;
                        end
                    end
                end
                S_REPORT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
